lcd_frame_decoder: RTL
======================

Name: lcd_frame_decoder

Overview:
- Sink side of the panel pixel interface. Consumes the den/hsync/vsync/RGB stream driven to the TFT panel.
- Recovers active-area pixel coordinates and samples the pixel at every board intersection.
- Rebuilds the stone-occupancy bitmap of the rendered frame and publishes it atomically once per complete frame.
- Used as an in-system loopback checker against the game's board_state.

Parameters:
- H_ACTIVE, 800, active pixels per line (den-high cycles)
- V_ACTIVE, 480, active lines per frame
- CELLS, 10, intersections per axis; bitmap width CELLS*CELLS
- GRID_X0, 199, active-area x of the board's left edge
- GRID_Y0, 19, active-area y of the board's top edge
- PITCH, 40, pixel spacing between intersections
- WHITE_TH, 8'hF0, per-channel threshold for a stone pixel
- IDLE_CYCLES, 2048, consecutive den-low clocks that define a frame gap

Ports:
- clk  in  1  pixel clock (dclk domain)
- rst  in  1  asynchronous, active-low reset
- den  in  1  data enable
- hsync  in  1  line sync, active low
- vsync  in  1  frame sync, active low
- R, G, B  in  8 each  pixel colour
- board_state  out  CELLS*CELLS  decoded occupancy; bit k = row k/CELLS, col k%CELLS
- frame_done  out  1  one-cycle pulse when board_state is updated
- frame_count  out  16  complete frames decoded; wraps at 16'hFFFF->0
- sync_lock  out  1  set after first complete frame
- frame_err  out  1  sticky; a frame ended short
- line_len_err  out  1  sticky; see Optional Feature
- line_cnt_err  out  1  sticky; see Optional Feature

Behaviour:
- Reset (rst=0, async): all outputs 0. Internal x, y, shadow bitmap and state are cleared. State = WAIT_FRAME.
- All inputs are sampled on posedge clk. There is no input pipeline beyond one register stage.
- Frame boundary: vsync low for any cycle, OR den low for IDLE_CYCLES consecutive clocks. The idle counter saturates and clears on den=1. The boundary clears y and the shadow bitmap and enters WAIT_FRAME.
- States:
  - WAIT_FRAME: leave to ACTIVE_LINE on den rising.
  - ACTIVE_LINE: x increments for each den=1 cycle starting at 0. On den falling, y increments and the state moves to HBLANK.
  - HBLANK: leave to ACTIVE_LINE on den rising, with x reset to 0. If y==V_ACTIVE, go to COMMIT instead.
  - COMMIT: one cycle. board_state <= shadow, frame_count++, frame_done=1, sync_lock=1. Then go to WAIT_FRAME.
- Frame-boundary detection overrides any state. If the boundary arrives with 0<y<V_ACTIVE, set frame_err, discard the shadow, and hold board_state.
- Sample grid:
  - Sample points are x = GRID_X0+(c+1)*PITCH and y = GRID_Y0+(r+1)*PITCH, for r,c in 0..CELLS-1.
  - Implement with phase counters (x_ph, y_ph) that reload at GRID_X0/GRID_Y0 and wrap at PITCH. No divider or modulo on x/y.
  - col/row indices saturate at CELLS-1. Points beyond the active area are never sampled.
- Classification: at a sample point with den=1, shadow[r*CELLS+c] <= (R>=WHITE_TH && G>=WHITE_TH && B>=WHITE_TH). Every bit is written once per frame.
- frame_done pulses exactly one clock per COMMIT, never during reset.
- Simultaneous COMMIT and frame boundary: COMMIT completes first, and the boundary is processed on the next cycle.
- Excess den after y==V_ACTIVE, before a boundary: pixels are ignored and no new commit occurs.

Optional Feature:
- Macro: LCD_FRAME_DECODER_TIMING_CHECK_EN
- Defined:
  - line_len_err sets when a den-high run length != H_ACTIVE.
  - line_cnt_err sets when a frame boundary or excess den follows y != V_ACTIVE.
  - Both flags are sticky until reset.
- Undefined: both outputs are tied to 0 and no checking logic is built.

Test Plan:
- Reset mid-frame: rst=0 at line 200 -> all outputs 0 within the same cycle. After release, no frame_done until a full 480-line frame arrives.
- Empty board: 2 frames of wood/black/green pixels -> board_state==0, frame_count==2, sync_lock=1, two frame_done pulses each 1 cycle wide.
- Single stone: white disc at row 4, col 4 (pixel x=399, y=219) -> board_state==(1<<44) after the frame. Previous value is held until that COMMIT.
- Corner stones: bits 0, 9, 90, 99 rendered -> board_state has exactly those 4 bits. No wrap into adjacent cells.
- Short frame: vsync after 300 lines -> frame_err=1, board_state unchanged, frame_count unchanged. The next complete frame commits normally.
- With macro defined: one line with 799 den cycles -> line_len_err=1, stays 1. The same stimulus without the macro -> flag stays 0.

Source files
------------

// File: rtl/lcd_frame_decoder.sv
// Panel-stream sink: recovers pixel coordinates, samples each board intersection, and publishes the occupancy bitmap once per complete frame.
// Optional timing checks are built when LCD_FRAME_DECODER_TIMING_CHECK_EN is defined.
module lcd_frame_decoder #(
   parameter int         H_ACTIVE    = 800,
   parameter int         V_ACTIVE    = 480,
   parameter int         CELLS       = 10,
   parameter int         GRID_X0     = 199,
   parameter int         GRID_Y0     = 19,
   parameter int         PITCH       = 40,
   parameter logic [7:0] WHITE_TH    = 8'hF0,
   parameter int         IDLE_CYCLES = 2048
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     den_i,
   input  logic                     hsync_i,
   input  logic                     vsync_i,
   input  logic [7:0]               r_i,
   input  logic [7:0]               g_i,
   input  logic [7:0]               b_i,
   output logic [CELLS*CELLS-1:0]   board_state_o,
   output logic                     frame_done_o,
   output logic [15:0]              frame_count_o,
   output logic                     sync_lock_o,
   output logic                     frame_err_o,
   output logic                     line_len_err_o,
   output logic                     line_cnt_err_o
);
   localparam int N   = CELLS * CELLS;
   localparam int XW  = $clog2(H_ACTIVE + 1);
   localparam int YW  = $clog2(V_ACTIVE + 1);
   localparam int CW  = $clog2(CELLS + 1);
   localparam int PW  = $clog2(PITCH + 1);
   localparam int IW  = $clog2(IDLE_CYCLES + 1);
   localparam int IXW = (N > 1) ? $clog2(N) : 1;

   localparam logic [XW-1:0] X_END  = XW'(H_ACTIVE);
   localparam logic [XW-1:0] GX0    = XW'(GRID_X0);
   localparam logic [YW-1:0] Y_END  = YW'(V_ACTIVE);
   localparam logic [YW-1:0] GY0    = YW'(GRID_Y0);
   localparam logic [CW-1:0] CMAX   = CW'(CELLS - 1);
   localparam logic [PW-1:0] PMAX   = PW'(PITCH - 1);
   localparam logic [IW-1:0] I_LAST = IW'(IDLE_CYCLES - 1);
   localparam logic [IW-1:0] I_MAX  = IW'(IDLE_CYCLES);

   typedef enum logic [1:0] {WAIT_FRAME, ACTIVE_LINE, HBLANK, COMMIT} state_e;

   state_e          state_q, state_d;
   logic [XW-1:0]   x_q, x_d;
   logic [YW-1:0]   y_q, y_d;
   logic [PW-1:0]   x_ph_q, x_ph_d, y_ph_q, y_ph_d;
   logic [CW-1:0]   col_q, col_d, row_q, row_d;
   logic            x_arm_q, x_arm_d, y_arm_q, y_arm_d;
   logic            x_done_q, x_done_d, y_done_q, y_done_d;
   logic [IW-1:0]   idle_q, idle_d;
   logic            den_prev_q, bnd_pend_q, bnd_pend_d;
   logic [N-1:0]    shadow_q, shadow_d, board_q, board_d;
   logic [15:0]     count_q, count_d;
   logic            done_q, done_d, lock_q, lock_d, ferr_q, ferr_d;

   logic            den_rise, bnd_raw, in_line, pix_ok, x_hit, y_hit, white;
   logic [IXW-1:0]  idx;
   logic            unused_hsync;

   // Line timing is recovered from den edges alone; hsync carries no extra information here.
   assign unused_hsync = hsync_i;

   function automatic logic [PW-1:0] ph_step(input logic [PW-1:0] p);
      return (p == PMAX) ? '0 : p + 1'b1;
   endfunction

   assign den_rise = den_i & ~den_prev_q;
   assign bnd_raw  = ~vsync_i | (~den_i & (idle_q == I_LAST));
   assign in_line  = (state_q == ACTIVE_LINE) ||
                     (((state_q == WAIT_FRAME) || (state_q == HBLANK)) && den_rise);
   assign pix_ok   = den_i && in_line && (y_q < Y_END);
   assign x_hit    = x_arm_q && (x_ph_q == '0) && !x_done_q;
   assign y_hit    = y_arm_q && (y_ph_q == '0) && !y_done_q;
   assign white    = (r_i >= WHITE_TH) && (g_i >= WHITE_TH) && (b_i >= WHITE_TH);
   assign idx      = IXW'(int'(row_q) * CELLS + int'(col_q));

`ifdef LCD_FRAME_DECODER_TIMING_CHECK_EN
   logic lle_q, lle_d, lce_q, lce_d;
   assign line_len_err_o = lle_q;
   assign line_cnt_err_o = lce_q;
`else
   assign line_len_err_o = 1'b0;
   assign line_cnt_err_o = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      x_ph_d     = x_ph_q;
      y_ph_d     = y_ph_q;
      col_d      = col_q;
      row_d      = row_q;
      x_arm_d    = x_arm_q;
      y_arm_d    = y_arm_q;
      x_done_d   = x_done_q;
      y_done_d   = y_done_q;
      shadow_d   = shadow_q;
      board_d    = board_q;
      count_d    = count_q;
      done_d     = 1'b0;
      lock_d     = lock_q;
      ferr_d     = ferr_q;
      bnd_pend_d = 1'b0;
      idle_d     = den_i ? '0 : ((idle_q == I_MAX) ? idle_q : idle_q + 1'b1);
`ifdef LCD_FRAME_DECODER_TIMING_CHECK_EN
      lle_d      = lle_q;
      lce_d      = lce_q;
`endif
      if (state_q == COMMIT) begin
         // A boundary landing on the commit cycle is deferred by one clock.
         board_d    = shadow_q;
         count_d    = count_q + 16'd1;
         done_d     = 1'b1;
         lock_d     = 1'b1;
         state_d    = WAIT_FRAME;
         bnd_pend_d = bnd_raw;
      end else if (bnd_raw || bnd_pend_q) begin
         if ((y_q != '0) && (y_q != Y_END)) begin
            ferr_d = 1'b1;
`ifdef LCD_FRAME_DECODER_TIMING_CHECK_EN
            lce_d  = 1'b1;
`endif
         end
         state_d  = WAIT_FRAME;
         y_d      = '0;
         x_d      = '0;
         shadow_d = '0;
         x_ph_d   = '0;
         y_ph_d   = '0;
         col_d    = '0;
         row_d    = '0;
         x_arm_d  = 1'b0;
         y_arm_d  = 1'b0;
         x_done_d = 1'b0;
         y_done_d = 1'b0;
      end else begin
         if (pix_ok) begin
            x_d = (x_q == X_END) ? x_q : x_q + 1'b1;
            if (x_q == GX0) begin
               x_arm_d  = 1'b1;
               x_ph_d   = ph_step('0);
               col_d    = '0;
               x_done_d = 1'b0;
            end else if (x_arm_q) begin
               x_ph_d = ph_step(x_ph_q);
               if (x_hit) begin
                  if (col_q == CMAX) x_done_d = 1'b1;
                  else               col_d    = col_q + 1'b1;
               end
            end
            if (x_hit && y_hit) shadow_d[idx] = white;
         end else begin
            x_d      = '0;
            x_ph_d   = '0;
            col_d    = '0;
            x_arm_d  = 1'b0;
            x_done_d = 1'b0;
         end

         unique case (state_q)
            WAIT_FRAME: begin
               if (den_rise) begin
                  if (y_q != Y_END) state_d = ACTIVE_LINE;
`ifdef LCD_FRAME_DECODER_TIMING_CHECK_EN
                  else              lce_d   = 1'b1;
`endif
               end
            end
            ACTIVE_LINE: begin
               if (!den_i) begin
                  y_d     = y_q + 1'b1;
                  state_d = HBLANK;
`ifdef LCD_FRAME_DECODER_TIMING_CHECK_EN
                  if (x_q != X_END) lle_d = 1'b1;
`endif
                  // Row phase advances once per completed line.
                  if (y_q == GY0) begin
                     y_arm_d  = 1'b1;
                     y_ph_d   = ph_step('0);
                     row_d    = '0;
                     y_done_d = 1'b0;
                  end else if (y_arm_q) begin
                     y_ph_d = ph_step(y_ph_q);
                     if (y_hit) begin
                        if (row_q == CMAX) y_done_d = 1'b1;
                        else               row_d    = row_q + 1'b1;
                     end
                  end
               end
            end
            HBLANK: begin
               if (y_q == Y_END) state_d = COMMIT;
               else if (den_rise) state_d = ACTIVE_LINE;
            end
            default: state_d = WAIT_FRAME;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= WAIT_FRAME;
         x_q        <= '0;
         y_q        <= '0;
         x_ph_q     <= '0;
         y_ph_q     <= '0;
         col_q      <= '0;
         row_q      <= '0;
         x_arm_q    <= 1'b0;
         y_arm_q    <= 1'b0;
         x_done_q   <= 1'b0;
         y_done_q   <= 1'b0;
         idle_q     <= '0;
         den_prev_q <= 1'b0;
         bnd_pend_q <= 1'b0;
         shadow_q   <= '0;
         board_q    <= '0;
         count_q    <= '0;
         done_q     <= 1'b0;
         lock_q     <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         x_ph_q     <= x_ph_d;
         y_ph_q     <= y_ph_d;
         col_q      <= col_d;
         row_q      <= row_d;
         x_arm_q    <= x_arm_d;
         y_arm_q    <= y_arm_d;
         x_done_q   <= x_done_d;
         y_done_q   <= y_done_d;
         idle_q     <= idle_d;
         den_prev_q <= den_i;
         bnd_pend_q <= bnd_pend_d;
         shadow_q   <= shadow_d;
         board_q    <= board_d;
         count_q    <= count_d;
         done_q     <= done_d;
         lock_q     <= lock_d;
         ferr_q     <= ferr_d;
      end
   end

`ifdef LCD_FRAME_DECODER_TIMING_CHECK_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lle_q <= 1'b0;
         lce_q <= 1'b0;
      end else begin
         lle_q <= lle_d;
         lce_q <= lce_d;
      end
   end
`endif

   assign board_state_o = board_q;
   assign frame_done_o  = done_q;
   assign frame_count_o = count_q;
   assign sync_lock_o   = lock_q;
   assign frame_err_o   = ferr_q;
endmodule
